// File: rtl/tc_mem_arbiter.sv
// Two-port arbiter sharing one single-port memory (combinational read, negedge write).
// Registers the granted command for one memory cycle and captures read data per port.
module tc_mem_arbiter #(
    parameter int BIT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BIT_WIDTH-1:0]  wdata0,
    input  logic [BIT_WIDTH-1:0]  wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [BIT_WIDTH-1:0]  rdata0,
    output logic [BIT_WIDTH-1:0]  rdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  mem_load,
    output logic                  mem_save,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BIT_WIDTH-1:0]  mem_in,
    input  logic [BIT_WIDTH-1:0]  mem_out
);

    logic                  last;
    logic                  hs;
    logic                  sel;
    logic                  cmd_vld;
    logic                  cmd_we;
    logic                  cmd_port;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [BIT_WIDTH-1:0]  cmd_wdata;

    // last==1 means port 1 won most recently, so port 0 wins the next contention
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (req0 && req1) begin
                if ((FIXED_PRIO != 0) || last) gnt0 = 1'b1;
                else                           gnt1 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign hs  = gnt0 | gnt1;
    assign sel = gnt1;

    // Command stage: granted request held for exactly one memory cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_vld   <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_port  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last      <= 1'b1;
        end else begin
            cmd_vld <= hs;
            if (hs) begin
                cmd_we    <= sel ? we1 : we0;
                cmd_port  <= sel;
                cmd_addr  <= sel ? addr1 : addr0;
                cmd_wdata <= sel ? wdata1 : wdata0;
                last      <= sel;
            end
        end
    end

    assign mem_load    = cmd_vld & ~cmd_we;
    assign mem_save    = cmd_vld & cmd_we;
    assign mem_address = cmd_addr;
    assign mem_in      = cmd_wdata;

    // Response stage: capture combinational memory output at the end of a read cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= mem_load & ~cmd_port;
            rvalid1 <= mem_load & cmd_port;
            if (mem_load && !cmd_port) rdata0 <= mem_out;
            if (mem_load && cmd_port)  rdata1 <= mem_out;
        end
    end

endmodule

// File: doc/tc_mem_arbiter.md
# tc_mem_arbiter

Two-port round-robin arbiter that shares one single-port memory (TC_Rom-style: combinational read when `load` is high, write on the negative clock edge when `save` is high) between two requesters, typically instruction fetch (port 0) and data load/store (port 1). The arbiter registers the granted command and drives the memory for exactly one cycle. It captures read data into a per-port register with a valid pulse. One access per cycle is sustained; writes are posted and produce no response.

## Interface
- `BIT_WIDTH`, 16: data word width.
- `ADDR_WIDTH`, 16: address width; must match the memory `address` port.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = port 0 always wins.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted).
- `req0`, `req1`  in  1  request valid, held until handshake.
- `we0`, `we1`  in  1  1 = write, 0 = read; qualified by req.
- `addr0`, `addr1`  in  ADDR_WIDTH  access address.
- `wdata0`, `wdata1`  in  BIT_WIDTH  write data.
- `gnt0`, `gnt1`  out  1  combinational ready; handshake = `reqN && gntN` at a posedge.
- `rdata0`, `rdata1`  out  BIT_WIDTH  captured read data, held until next read completion on that port.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: rdataN updated.
- `mem_load`  out  1  to memory `load`.
- `mem_save`  out  1  to memory `save`.
- `mem_address`  out  ADDR_WIDTH  to memory `address`.
- `mem_in`  out  BIT_WIDTH  to memory `in`.
- `mem_out`  in  BIT_WIDTH  from memory `out`.

## Operation
- Arbitration is combinational from the current reqs:
  - Only one port requesting: that port is granted.
  - Both requesting, RR mode: the port opposite `last` is granted.
  - Both requesting, FIXED_PRIO=1: port 0 is granted.
  - At most one gnt is high. gnt is 0 for a port whose req is 0.
- On a handshake edge, the arbiter registers:
  - the command: `cmd_vld`=1, `cmd_we`, `cmd_addr`, `cmd_wdata`, `cmd_port`;
  - `last` = granted port.
- With no handshake, `cmd_vld`=0. The address and data registers hold their values.
- Memory drive, cycle after the handshake:
  - `mem_load` = `cmd_vld & ~cmd_we`;
  - `mem_save` = `cmd_vld & cmd_we`;
  - `mem_address` = `cmd_addr`;
  - `mem_in` = `cmd_wdata`.
- The write commits at the negedge inside the command cycle.
- Read capture: at the posedge ending a read command cycle, `mem_out` is loaded into `rdata[cmd_port]`, and `rvalid[cmd_port]`=1 for the following cycle only.
- Reset (`rst`=0) forces the following immediately, without waiting for a clock:
  - `cmd_vld`=0, so `mem_load`=`mem_save`=0;
  - `rvalid0`=`rvalid1`=0;
  - `rdata0`=`rdata1`=0;
  - `mem_address`=0, `mem_in`=0;
  - `last`=1, so port 0 wins the first contention.
- gnt outputs are forced to 0 while `rst`=0.

## Timing
- Edge E0: handshake. Cycle E0–E1: memory access. Write commits at the negedge in that cycle.
- Read: `rvalidN`=1 and `rdataN` valid in cycle E1–E2. Latency is 2 posedges from handshake.
- Throughput is one handshake per cycle. Back-to-back commands pipeline with no bubble.
- Read-after-write to the same address in consecutive handshakes returns the new data. The write commits at the negedge before the read cycle, and the read is combinational.
- Both ports requesting continuously in RR mode: grants alternate 0,1,0,1… FIXED_PRIO=1 starves port 1.
- Reset mid-access:
  - An in-flight write is dropped if `rst` falls before its negedge.
  - An in-flight read returns no rvalid.
  - The requester must re-issue after reset.
- Release of reset: first possible handshake at the first posedge with `rst`=1.

## Test plan
- Reset values: hold `rst`=0 with reqs high → gnt0=gnt1=0, mem_load=mem_save=0, rvalid=0, rdata=0. Release → port 0 granted first.
- Single write then read: port 0 writes 0xBEEF to addr 0x0010, then reads 0x0010 on the next cycle. Required:
  - mem_save=1 for exactly one cycle;
  - rvalid0 pulses 2 edges after the read handshake;
  - rdata0=0xBEEF.
- Round-robin contention: both ports read continuously (mem preloaded addr 1=0x1111, addr 2=0x2222; port 0 addr 1, port 1 addr 2). Required:
  - gnt alternates 0,1,0,1;
  - rvalid0/rvalid1 alternate every cycle;
  - rdata0=0x1111, rdata1=0x2222.
- FIXED_PRIO=1, both requesting for 5 cycles → gnt0=1 all 5 cycles, gnt1=0. Drop req0 → gnt1=1 in that same cycle.
- Reset mid-access: port 1 write of 0x1234 to addr 5 handshakes, then `rst` pulses low before the negedge → mem_save drops immediately and addr 5 keeps its old value. Read after reset returns the old value.
- Hold behaviour: read 0x00AA into port 0 with no further reads for 10 cycles → rdata0 stays 0x00AA and rvalid0 stays 0 after the single pulse.
